// File: rtl/datamem_responder.sv
// datamem_responder: responder end of the CPU data-memory request interface.
// Accepts one load/store at a time (valid/ready), performs it on an internal
// word-addressed RAM at the acceptance edge, and returns the response after
// LATENCY cycles through a second valid/ready handshake.
//
// Ports:
//   clk, rst          clock (rising edge), asynchronous active-low reset
//   req_valid/ready   request handshake; ready only while idle
//   req_we            1 = store, 0 = load
//   req_addrmode      0 = word access, 1 = byte access
//   req_addr          byte address; word index = req_addr[ADDR_BITS+1:2]
//   req_wdata         store data (byte stores use bits 7:0)
//   rsp_valid/ready   response handshake
//   rsp_rdata         load data (zero-extended for bytes), 0 for stores
//   rsp_err           misaligned word access flag
//
// Optional feature macro: DATAMEM_MISALIGN_ERR_EN
//   defined     - word accesses with req_addr[1:0] != 0 are flagged: store
//                 suppressed, load returns 0, rsp_err = 1
//   not defined - low address bits ignored for word accesses, rsp_err = 0
module datamem_responder #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_BITS  = 10,
    parameter int unsigned LATENCY    = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic                  req_addrmode,
    input  logic [DATA_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err
);

    localparam int unsigned DEPTH = 1 << ADDR_BITS;
    localparam int unsigned CNT_W = 4;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  rsp_valid_d;
    logic [DATA_WIDTH-1:0] rsp_rdata_d;
    logic                  rsp_err_d;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_BITS-1:0]  idx_c;
    logic [4:0]            lane_lsb_c;
    logic [DATA_WIDTH-1:0] rd_word_c;
    logic [DATA_WIDTH-1:0] rd_data_c;
    logic [DATA_WIDTH-1:0] wr_word_c;
    logic                  misalign_c;
    logic                  mem_we_c;
    logic                  unused_addr_hi;

    // Upper address bits wrap away; index the RAM by word.
    assign idx_c          = req_addr[ADDR_BITS+1:2];
    assign lane_lsb_c     = {req_addr[1:0], 3'b000};
    assign unused_addr_hi = ^req_addr[DATA_WIDTH-1:ADDR_BITS+2];

`ifdef DATAMEM_MISALIGN_ERR_EN
    assign misalign_c = !req_addrmode && (req_addr[1:0] != 2'b00);
`else
    assign misalign_c = 1'b0;
`endif

    // Ready is a pure decode of the state, held low during reset.
    assign req_ready = rst && (state_q == IDLE);

    // Read path and byte-merge for stores.
    always_comb begin
        rd_word_c = mem[idx_c];
        wr_word_c = rd_word_c;
        if (req_addrmode) begin
            rd_data_c = DATA_WIDTH'(rd_word_c[lane_lsb_c +: 8]);
            wr_word_c[lane_lsb_c +: 8] = req_wdata[7:0];
        end else begin
            rd_data_c = rd_word_c;
            wr_word_c = req_wdata;
        end
    end

    // Next-state and response register logic.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = rsp_rdata;
        rsp_err_d   = rsp_err;
        mem_we_c    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (req_valid) begin
                    mem_we_c    = req_we && !misalign_c;
                    rsp_rdata_d = (req_we || misalign_c) ? '0 : rd_data_c;
                    rsp_err_d   = misalign_c;
                    cnt_d       = CNT_LOAD;
                    state_d     = (LATENCY == 1) ? RESP : BUSY;
                end
            end
            BUSY: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                // rsp_valid is registered, so it rises one edge after entry.
                if (rsp_valid && rsp_ready) begin
                    state_d = IDLE;
                end else begin
                    rsp_valid_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and response registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rsp_valid <= rsp_valid_d;
            rsp_rdata <= rsp_rdata_d;
            rsp_err   <= rsp_err_d;
        end
    end

    // RAM write port; contents survive reset.
    always_ff @(posedge clk) begin
        if (mem_we_c) begin
            mem[idx_c] <= wr_word_c;
        end
    end

endmodule

// File: tb/tb_datamem_responder.sv
// tb_datamem_responder: scoreboard bench for datamem_responder (LATENCY = 2,
// ADDR_BITS = 10). Expected responses are queued when a request is issued
// and compared when the response handshake occurs. Honours
// DATAMEM_MISALIGN_ERR_EN for the misaligned-store expectations.
module tb_datamem_responder;

    localparam int unsigned DW  = 32;
    localparam int unsigned AB  = 10;
    localparam int unsigned LAT = 2;

`ifdef DATAMEM_MISALIGN_ERR_EN
    localparam bit MIS_EN = 1'b1;
`else
    localparam bit MIS_EN = 1'b0;
`endif

    typedef struct packed {
        logic [DW-1:0] rdata;
        logic          err;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic          req_we = 1'b0;
    logic          req_addrmode = 1'b0;
    logic [DW-1:0] req_addr = '0;
    logic [DW-1:0] req_wdata = '0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b1;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_err;

    exp_t sb_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    datamem_responder #(
        .DATA_WIDTH(DW),
        .ADDR_BITS (AB),
        .LATENCY   (LAT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_we      (req_we),
        .req_addrmode(req_addrmode),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_rdata   (rsp_rdata),
        .rsp_err     (rsp_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Response monitor: sampled on the falling edge, inputs only move after rising edges.
    always @(negedge clk) begin
        if (rst && rsp_valid && rsp_ready) begin
            if (sb_q.size() == 0) begin
                check("rsp_unexpected", 32'(rsp_valid), 32'd0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check("rsp_rdata", rsp_rdata, e.rdata);
                check("rsp_err", 32'(rsp_err), 32'(e.err));
            end
        end
    end

    // Issue one request (called just after a rising edge) and wait for rsp_valid.
    task automatic issue(input logic we, input logic mode, input logic [DW-1:0] addr,
                         input logic [DW-1:0] wdata, input logic [DW-1:0] exp_rd,
                         input logic exp_err);
        int k;
        exp_t e;
        check("req_ready_idle", 32'(req_ready), 32'd1);
        e.rdata = exp_rd;
        e.err   = exp_err;
        sb_q.push_back(e);
        req_valid    = 1'b1;
        req_we       = we;
        req_addrmode = mode;
        req_addr     = addr;
        req_wdata    = wdata;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_wdata = 32'hBAD0_BAD0;
        k = 0;
        while (!rsp_valid && k < 20) begin
            @(posedge clk);
            #1;
            k++;
        end
        check("latency", 32'(k), 32'(LAT));
    endtask

    // Wait for the response handshake to retire and the responder to return to idle.
    task automatic finish_rsp();
        int k;
        k = 0;
        while (rsp_valid && k < 40) begin
            @(posedge clk);
            #1;
            k++;
        end
        check("rsp_retired", 32'(rsp_valid), 32'd0);
    endtask

    task automatic txn(input logic we, input logic mode, input logic [DW-1:0] addr,
                       input logic [DW-1:0] wdata, input logic [DW-1:0] exp_rd,
                       input logic exp_err);
        issue(we, mode, addr, wdata, exp_rd, exp_err);
        finish_rsp();
    endtask

    logic [31:0] model [8];

    initial begin
        int hits;
        int w;
        int lane;
        logic we;
        logic bm;
        logic [31:0] wd;
        logic [31:0] er;
        logic [31:0] ad;

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        check("rst_req_ready", 32'(req_ready), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_rdata", rsp_rdata, 32'd0);
        check("rst_rsp_err", 32'(rsp_err), 32'd0);
        rst = 1'b1;
        #1;
        check("post_rst_req_ready", 32'(req_ready), 32'd1);
        check("post_rst_rsp_valid", 32'(rsp_valid), 32'd0);
        @(posedge clk);
        #1;

        // Word store then load
        txn(1'b1, 1'b0, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0);
        txn(1'b0, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0);

        // Byte store over a word, then word and byte loads
        txn(1'b1, 1'b0, 32'h10, 32'h11223344, 32'h0, 1'b0);
        txn(1'b1, 1'b1, 32'h13, 32'hFFFFFFAB, 32'h0, 1'b0);
        txn(1'b0, 1'b0, 32'h10, 32'h0, 32'hAB223344, 1'b0);
        txn(1'b0, 1'b1, 32'h13, 32'h0, 32'h000000AB, 1'b0);
        txn(1'b0, 1'b1, 32'h11, 32'h0, 32'h00000033, 1'b0);

        // Backpressure: response held while rsp_ready is low
        rsp_ready = 1'b0;
        issue(1'b0, 1'b0, 32'h10, 32'h0, 32'hAB223344, 1'b0);
        for (int i = 0; i < 5; i++) begin
            check("bp_rsp_valid", 32'(rsp_valid), 32'd1);
            check("bp_rsp_rdata", rsp_rdata, 32'hAB223344);
            check("bp_req_ready", 32'(req_ready), 32'd0);
            @(posedge clk);
            #1;
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp_release_req_ready", 32'(req_ready), 32'd1);
        check("bp_release_rsp_valid", 32'(rsp_valid), 32'd0);

        // Address wrap-around
        txn(1'b1, 1'b0, 32'h1000, 32'h55, 32'h0, 1'b0);
        txn(1'b0, 1'b0, 32'h0000, 32'h0, 32'h00000055, 1'b0);

        // Reset while BUSY: store is committed, response dropped
        req_valid    = 1'b1;
        req_we       = 1'b1;
        req_addrmode = 1'b0;
        req_addr     = 32'h20;
        req_wdata    = 32'h12345678;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        rst = 1'b0;
        #1;
        check("midrst_req_ready", 32'(req_ready), 32'd0);
        check("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("midrst_release_req_ready", 32'(req_ready), 32'd1);
        hits = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            if (rsp_valid) hits++;
        end
        check("midrst_no_rsp", 32'(hits), 32'd0);
        txn(1'b0, 1'b0, 32'h20, 32'h0, 32'h12345678, 1'b0);

        // Misaligned word store
        txn(1'b1, 1'b0, 32'h20, 32'h0, 32'h0, 1'b0);
        txn(1'b1, 1'b0, 32'h22, 32'hFFFFFFFF, 32'h0, MIS_EN);
        txn(1'b0, 1'b0, 32'h20, 32'h0, MIS_EN ? 32'h0 : 32'hFFFFFFFF, 1'b0);

        // Random aligned traffic against a small reference model
        for (int i = 0; i < 8; i++) begin
            model[i] = $urandom;
            txn(1'b1, 1'b0, 32'h100 + 32'(i * 4), model[i], 32'h0, 1'b0);
        end
        for (int i = 0; i < 24; i++) begin
            w    = $urandom_range(0, 7);
            lane = $urandom_range(0, 3);
            we   = 1'($urandom_range(0, 1));
            bm   = 1'($urandom_range(0, 1));
            wd   = $urandom;
            ad   = 32'h100 + 32'(w * 4) + (bm ? 32'(lane) : 32'd0);
            er   = 32'h0;
            if (we) begin
                if (bm) model[w][lane*8 +: 8] = wd[7:0];
                else    model[w] = wd;
            end else begin
                er = bm ? {24'h0, model[w][lane*8 +: 8]} : model[w];
            end
            txn(we, bm, ad, wd, er, 1'b0);
        end

        repeat (3) @(posedge clk);
        #1;
        check("sb_drained", 32'(sb_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
